// File: rtl/bool_sweep_pkg.sv
// Shared types and helpers for the Boolean truth-table sweeper.
package bool_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of input vectors for an n-input block (NUM_VEC = 1 << N_IN)
  function automatic int unsigned num_vec(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/bool_sweep_checker_if.sv
// Control, expected-table and block-under-test signals of the sweeper.
interface bool_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
);
  logic              start;
  logic              cfg_we;
  logic [N_IN-1:0]   cfg_addr;
  logic [N_OUT-1:0]  cfg_data;
  logic [N_IN-1:0]   vec_out;
  logic [N_OUT-1:0]  dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_cnt;
  logic              first_fail_valid;
  logic [N_IN-1:0]   first_fail_addr;

  modport master (
    output start, cfg_we, cfg_addr, cfg_data, dut_in,
    input  vec_out, busy, done, pass, err_cnt, first_fail_valid, first_fail_addr
  );

  modport slave (
    input  start, cfg_we, cfg_addr, cfg_data, dut_in,
    output vec_out, busy, done, pass, err_cnt, first_fail_valid, first_fail_addr
  );
endinterface

// File: rtl/bool_exp_table.sv
// Expected truth table: 2^N_IN x N_OUT register file, one write port,
// one combinational read port.
module bool_exp_table
  import bool_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata
);
  localparam int unsigned NUM_VEC = num_vec(N_IN);

  logic [N_OUT-1:0] r_mem [NUM_VEC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/bool_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector, holds it for
// SETTLE cycles, then compares the block's outputs against the table.
module bool_sweep_checker
  import bool_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bool_sweep_checker_if.slave  bus
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  state_t            r_state;
  logic [SW-1:0]     r_settle;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_err;
  logic              r_ffv;
  logic [N_IN-1:0]   r_ffa;

  logic [N_OUT-1:0]  w_exp;
  logic              w_tbl_we;
  logic              w_sample;
  logic              w_mismatch;
  logic [N_IN:0]     w_err_next;

  bool_exp_table #(.N_IN(N_IN), .N_OUT(N_OUT)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_tbl_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (r_vec),
    .rdata (w_exp)
  );

  assign w_tbl_we   = bus.cfg_we && (r_state == ST_IDLE);
  assign w_sample   = (r_state == ST_HOLD) && (r_settle == SETTLE_LAST);
  assign w_mismatch = (bus.dut_in != w_exp);
  // Count including this edge's compare, so pass is valid together with done
  assign w_err_next = (w_sample && w_mismatch) ? r_err + {{N_IN{1'b0}}, 1'b1} : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ffv    <= 1'b0;
      r_ffa    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state  <= ST_HOLD;
            r_busy   <= 1'b1;
            r_vec    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
            r_ffv    <= 1'b0;
            r_ffa    <= '0;
          end
        end
        ST_HOLD: begin
          if (w_sample) begin
            r_err <= w_err_next;
            if (w_mismatch && !r_ffv) begin
              r_ffv <= 1'b1;
              r_ffa <= r_vec;
            end
            if (r_vec == VEC_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_vec    <= r_vec + {{(N_IN-1){1'b0}}, 1'b1};
              r_settle <= '0;
            end
          end else begin
            r_settle <= r_settle + {{(SW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_vec   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec_out          = r_vec;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_cnt          = r_err;
  assign bus.first_fail_valid = r_ffv;
  assign bus.first_fail_addr  = r_ffa;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Scoreboard bench: two sweepers (SETTLE=1 and SETTLE=3) checking a full adder
// and a 2-cycle registered full adder.
module tb_bool_sweep_checker;

  typedef struct {
    bit pass;
    int err;
    bit ffv;
    int ffa;
    int lat;
    int t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  bit   sel_dly = 1'b0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  // Hand-written full-adder table {0, carry, sum} for inputs {cin, b, a}
  logic [2:0] FA_TBL [8] = '{3'b000, 3'b001, 3'b001, 3'b010,
                             3'b001, 3'b010, 3'b010, 3'b011};

  bool_sweep_checker_if #(.N_IN(3), .N_OUT(3)) b1 ();
  bool_sweep_checker_if #(.N_IN(3), .N_OUT(3)) b3 ();

  bool_sweep_checker #(.N_IN(3), .N_OUT(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  bool_sweep_checker #(.N_IN(3), .N_OUT(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] fa(input logic [2:0] v);
    logic s, c;
    s = v[0] ^ v[1] ^ v[2];
    c = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    return {1'b0, c, s};
  endfunction

  // Blocks under test: combinational adder and a 2-stage registered adder
  logic [2:0] d1a, d1b, d3a, d3b;
  always @(posedge clk) begin
    d1a <= fa(b1.vec_out);
    d1b <= d1a;
    d3a <= fa(b3.vec_out);
    d3b <= d3a;
  end
  assign b1.dut_in = sel_dly ? d1b : fa(b1.vec_out);
  assign b3.dut_in = d3b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit p, input int e, input bit v, input int a, input int l);
    exp_t r;
    r.pass = p; r.err = e; r.ffv = v; r.ffa = a; r.lat = l; r.t0 = 0;
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (b1.done) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("pass1", b1.pass, e1.pass);
        chk("err_cnt1", b1.err_cnt, e1.err);
        chk("ffv1", b1.first_fail_valid, e1.ffv);
        chk("ffa1", b1.first_fail_addr, e1.ffa);
        chk("done_lat1", cyc - 1 - e1.t0, e1.lat);
      end
    end else if (b1.busy && q1.size() != 0) begin
      chk("vec_out1", b1.vec_out, cyc - 1 - q1[0].t0);
    end
    if (b3.done) begin
      if (q3.size() == 0) chk("done3_unexpected", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk("pass3", b3.pass, e3.pass);
        chk("err_cnt3", b3.err_cnt, e3.err);
        chk("ffv3", b3.first_fail_valid, e3.ffv);
        chk("ffa3", b3.first_fail_addr, e3.ffa);
        chk("done_lat3", cyc - 1 - e3.t0, e3.lat);
      end
    end else if (b3.busy && q3.size() != 0) begin
      chk("vec_out3", b3.vec_out, (cyc - 1 - q3[0].t0) / 3);
    end
  end

  task automatic wr(input int a, input logic [2:0] d);
    @(negedge clk);
    b1.cfg_we = 1'b1; b1.cfg_addr = 3'(a); b1.cfg_data = d;
    b3.cfg_we = 1'b1; b3.cfg_addr = 3'(a); b3.cfg_data = d;
    @(posedge clk);
    #1;
    b1.cfg_we = 1'b0;
    b3.cfg_we = 1'b0;
  endtask

  task automatic load_fa();
    for (int i = 0; i < 8; i++) wr(i, FA_TBL[i]);
  endtask

  task automatic go(input int which, input exp_t e, input bit wr_too,
                    input int a, input logic [2:0] d);
    @(negedge clk);
    if (which == 1) b1.start = 1'b1; else b3.start = 1'b1;
    if (wr_too) begin
      b1.cfg_we = 1'b1; b1.cfg_addr = 3'(a); b1.cfg_data = d;
    end
    @(posedge clk);
    e.t0 = cyc;
    if (which == 1) q1.push_back(e); else q3.push_back(e);
    #1;
    b1.start = 1'b0; b3.start = 1'b0; b1.cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    if (q1.size() != 0 || q3.size() != 0) begin
      chk("done_timeout", q1.size() + q3.size(), 0);
      q1.delete();
      q3.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, b1.busy, 0);
    chk({tag, "_done"}, b1.done, 0);
    chk({tag, "_pass"}, b1.pass, 0);
    chk({tag, "_err"}, b1.err_cnt, 0);
    chk({tag, "_ffv"}, b1.first_fail_valid, 0);
    chk({tag, "_ffa"}, b1.first_fail_addr, 0);
    chk({tag, "_vec"}, b1.vec_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.start = 1'b0; b1.cfg_we = 1'b0; b1.cfg_addr = '0; b1.cfg_data = '0;
    b3.start = 1'b0; b3.cfg_we = 1'b0; b3.cfg_addr = '0; b3.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    load_fa();
    // Reference full adder, SETTLE=1
    go(1, mk(1, 0, 0, 0, 8), 0, 0, 3'b000);
    drain();
    chk("hold_pass", b1.pass, 1);
    chk("hold_err", b1.err_cnt, 0);

    // Registered adder: SETTLE=3 passes, SETTLE=1 fails at vectors 1,2,3,6,7
    go(3, mk(1, 0, 0, 0, 24), 0, 0, 3'b000);
    drain();
    sel_dly = 1'b1;
    repeat (4) @(posedge clk);
    go(1, mk(0, 5, 1, 1, 8), 0, 0, 3'b000);
    drain();
    sel_dly = 1'b0;

    // Single corrupted entry
    wr(5, FA_TBL[5] ^ 3'b100);
    go(1, mk(0, 1, 1, 5, 8), 0, 0, 3'b000);
    drain();
    wr(5, FA_TBL[5]);

    // Every entry inverted: counter reaches 8 without overflow
    for (int i = 0; i < 8; i++) wr(i, ~FA_TBL[i]);
    go(1, mk(0, 8, 1, 0, 8), 0, 0, 3'b000);
    drain();
    load_fa();

    // start and cfg_we pulsed mid-sweep must be ignored
    go(1, mk(1, 0, 0, 0, 8), 0, 0, 3'b000);
    repeat (3) @(negedge clk);
    b1.start = 1'b1; b1.cfg_we = 1'b1; b1.cfg_addr = 3'd6; b1.cfg_data = 3'b111;
    @(posedge clk);
    #1;
    b1.start = 1'b0; b1.cfg_we = 1'b0;
    drain();
    go(1, mk(1, 0, 0, 0, 8), 0, 0, 3'b000);
    drain();

    // start with simultaneous write: the sweep sees the new entry
    go(1, mk(0, 1, 1, 0, 8), 1, 0, 3'b111);
    drain();
    wr(0, FA_TBL[0]);

    // Reset at vector 4, then an empty table fails on vectors 1..7
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("vec_before_reset", b1.vec_out, 4);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    go(1, mk(0, 7, 1, 1, 8), 0, 0, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bool_sweep_checker.md
# bool_sweep_checker

Self-checking truth-table sweeper for combinational Boolean blocks with N inputs and M outputs. On `start` it drives every input vector 0 … 2^N_IN−1 onto the block under test and holds each for a programmable settle time. It samples the block's outputs and compares them against an expected truth table loaded beforehand. It sits between a programmable expected-table interface and any combinational function block, and replaces hand-written exhaustive stimulus with a hardware pass/fail result.

## Interface
- `N_IN`, 3, number of inputs to the block under test (1–8)
- `N_OUT`, 3, number of outputs from the block under test (1–16)
- `SETTLE`, 1, cycles each vector is held before its sample edge (≥1)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin sweep; honoured only in IDLE
- `cfg_we`  in  1  expected-table write strobe; honoured only when not busy
- `cfg_addr`  in  N_IN  table entry (input vector) to write
- `cfg_data`  in  N_OUT  expected outputs for `cfg_addr`
- `vec_out`  out  N_IN  vector driven to the block's inputs
- `dut_in`  in  N_OUT  block's outputs, sampled by the checker
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  last completed sweep had zero mismatches
- `err_cnt`  out  N_IN+1  mismatch count of current/last sweep
- `first_fail_valid`  out  1  at least one mismatch seen
- `first_fail_addr`  out  N_IN  vector of the first mismatch

## Operation
- FSM states: IDLE → HOLD → DONE → IDLE.
- **IDLE**
  - `busy` = 0.
  - `cfg_we` writes `cfg_data` into table entry `cfg_addr` on the clock edge.
  - When `start` = 1, the FSM moves to HOLD. On that same edge it sets `vec_out` = 0 and `settle_cnt` = 0, and clears `err_cnt`, `pass`, `first_fail_valid` and `first_fail_addr`.
- **HOLD**
  - `busy` = 1.
  - `settle_cnt` increments every cycle.
  - On the edge where `settle_cnt` = SETTLE−1, `dut_in` is compared against `table[vec_out]` (full N_OUT-bit equality).
  - On a mismatch:
    - `err_cnt` increments.
    - If `first_fail_valid` = 0, it is set to 1 and `first_fail_addr` latches `vec_out`.
  - On the same edge, if `vec_out` = 2^N_IN−1 the FSM goes to DONE. Otherwise `vec_out` increments and `settle_cnt` returns to 0.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - `pass` is set to 1 iff `err_cnt` = 0. The count already includes the final vector's compare.
  - The FSM then returns to IDLE.
- `err_cnt` cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- `pass`, `err_cnt` and `first_fail_*` hold their values after DONE until the next accepted `start`.
- Boundary and ignore rules:
  - `start` while `busy` or in DONE: ignored.
  - `cfg_we` while `busy` or in DONE: ignored, table unchanged.
  - `start` and `cfg_we` asserted together in IDLE: the write lands, and the sweep uses the new value.
  - `vec_out` does not wrap: it stays at 2^N_IN−1 through DONE and then returns to 0 in IDLE.
- Reset (any time, including mid-sweep) drives the following to 0:
  - all outputs;
  - FSM state (IDLE);
  - `settle_cnt`;
  - every table entry.

## Timing
- `start` sampled at edge t0 → `busy` = 1 and `vec_out` = 0 from t0.
- Vector k is driven for SETTLE cycles and sampled at edge t0 + (k+1)·SETTLE.
- DONE occupies the cycle after the last sample edge:
  - `done` is high from edge t0 + 2^N_IN·SETTLE until edge t0 + 2^N_IN·SETTLE + 1;
  - `busy` falls at edge t0 + 2^N_IN·SETTLE + 1.
- The table write has one-cycle latency: an entry written at edge t is visible from cycle t+1.
- `dut_in` must be stable SETTLE cycles after `vec_out` changes; the checker registers nothing on `dut_in` before its sample edge.

## Structure
- Shared package `bool_sweep_pkg`:
  - FSM state encoding (IDLE=2'd0, HOLD=2'd1, DONE=2'd2);
  - the helper constant `NUM_VEC` = 1<<N_IN.
- Sub-module `bool_exp_table`:
  - 2^N_IN × N_OUT register file;
  - asynchronous reset to zero;
  - one write port (`we`, `waddr`, `wdata`) and one combinational read port (`raddr` = `vec_out`).
- Top level: FSM, `settle_cnt`, vector counter, comparator and result registers.

## Test plan
- **Default parameters, full-adder reference:**
  - Stimulus: load a full-adder table (sum, carry, 0) and connect a correct full adder; assert `start`.
  - Response: `done` at t0+8; `pass` = 1; `err_cnt` = 0; `first_fail_valid` = 0; `vec_out` steps 0…7.
- **Single-entry mismatch:**
  - Stimulus: corrupt table entry 5.
  - Response: `err_cnt` = 1, `first_fail_addr` = 5, `pass` = 0.
- **Full mismatch:**
  - Stimulus: invert every table entry.
  - Response: `err_cnt` = 8 (4'b1000, no overflow); `first_fail_addr` = 0.
- **Settle time:**
  - Stimulus: SETTLE = 3 with a block that has a 2-cycle registered delay.
  - Response: `pass` = 1, `done` at t0+24; with SETTLE = 1 the same block gives `pass` = 0.
- **Ignored inputs while busy:**
  - Stimulus: pulse `start` and `cfg_we` mid-sweep.
  - Response: no restart, table unchanged, result identical to an undisturbed run.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n` = 0 at vector 4.
  - Response: all outputs go to 0 immediately, and the table reads back 0 on a subsequent sweep.
